// File: rtl/t08_touch_event_queue.sv
// Touch event queue: captures I2C touch frames, classifies them into
// press/move/release events and buffers them in a show-ahead FIFO.
module t08_touch_event_queue #(
  parameter int DEPTH       = 4,
  parameter int X_MAX       = 320,
  parameter int Y_MAX       = 480,
  parameter int MOVE_THRESH = 4
) (
  input  logic                     clk,
  input  logic                     nRst,
  input  logic                     en,
  input  logic [31:0]              frame,
  input  logic                     done,
  output logic                     evt_valid,
  output logic [1:0]               evt_type,
  output logic [11:0]              evt_x,
  output logic [11:0]              evt_y,
  input  logic                     evt_ready,
  output logic                     touching,
  output logic                     overflow,
  input  logic                     clr_ovf,
  output logic [7:0]               reject_cnt,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] T_PRESS   = 2'b00;
  localparam logic [1:0] T_RELEASE = 2'b01;
  localparam logic [1:0] T_MOVE    = 2'b10;

  typedef enum logic {RELEASED, PRESSED} state_t;

  state_t            state_q, state_d;
  logic              done_q, cap_pend_q;
  logic [1:0]        cap_ev_q;
  logic [11:0]       cap_x_q, cap_y_q;
  logic [11:0]       last_x_q, last_y_q;
  logic [1:0]        mem_t_q [DEPTH];
  logic [11:0]       mem_x_q [DEPTH];
  logic [11:0]       mem_y_q [DEPTH];
  logic [AW-1:0]     wr_q, rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        head_t_q, head_t_d;
  logic [11:0]       head_x_q, head_x_d;
  logic [11:0]       head_y_q, head_y_d;
  logic              ovf_q;
  logic [7:0]        rej_q;

  logic              rej, far, upd_last;
  logic              push_req, push_ok, pop, full, drop;
  logic [1:0]        push_t;
  logic signed [12:0] dx, dy;
  logic [12:0]       adx, ady;
  logic              unused_bits;

  assign unused_bits = ^{frame[29:28], frame[15:12]};

  always_comb begin
    dx  = $signed({1'b0, cap_x_q}) - $signed({1'b0, last_x_q});
    dy  = $signed({1'b0, cap_y_q}) - $signed({1'b0, last_y_q});
    adx = dx[12] ? 13'(-dx) : 13'(dx);
    ady = dy[12] ? 13'(-dy) : 13'(dy);
    far = (adx >= 13'(MOVE_THRESH)) || (ady >= 13'(MOVE_THRESH));
    rej = (cap_ev_q == 2'b11) || (cap_x_q >= 12'(X_MAX))
       || (cap_y_q >= 12'(Y_MAX));

    state_d  = state_q;
    upd_last = 1'b0;
    push_req = 1'b0;
    push_t   = T_PRESS;
    if (cap_pend_q && !rej) begin
      if (state_q == RELEASED) begin
        if (cap_ev_q != 2'b01) begin
          push_req = 1'b1;
          push_t   = T_PRESS;
          upd_last = 1'b1;
          state_d  = PRESSED;
        end
      end else if (cap_ev_q == 2'b01) begin
        push_req = 1'b1;
        push_t   = T_RELEASE;
        state_d  = RELEASED;
      end else if (far) begin
        push_req = 1'b1;
        push_t   = T_MOVE;
        upd_last = 1'b1;
      end
    end

    pop     = (cnt_q != '0) && evt_ready;
    full    = (cnt_q == CW'(DEPTH));
    push_ok = push_req && (!full || pop);
    drop    = push_req && !push_ok;
    cnt_d   = cnt_q + CW'(push_ok) - CW'(pop);
    rd_d    = pop ? rd_q + 1'b1 : rd_q;

    // New head may be the entry being written this very cycle
    head_t_d = head_t_q;
    head_x_d = head_x_q;
    head_y_d = head_y_q;
    if (cnt_d != '0) begin
      if (push_ok && (wr_q == rd_d)) begin
        head_t_d = push_t;
        head_x_d = cap_x_q;
        head_y_d = cap_y_q;
      end else begin
        head_t_d = mem_t_q[rd_d];
        head_x_d = mem_x_q[rd_d];
        head_y_d = mem_y_q[rd_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_t_q[wr_q] <= push_t;
      mem_x_q[wr_q] <= cap_x_q;
      mem_y_q[wr_q] <= cap_y_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q    <= RELEASED;
      done_q     <= 1'b1;
      cap_pend_q <= 1'b0;
      cap_ev_q   <= '0;
      cap_x_q    <= '0;
      cap_y_q    <= '0;
      last_x_q   <= '0;
      last_y_q   <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      head_t_q   <= '0;
      head_x_q   <= '0;
      head_y_q   <= '0;
      ovf_q      <= 1'b0;
      rej_q      <= '0;
    end else begin
      done_q     <= done;
      cap_pend_q <= en && done && !done_q;
      if (en && done && !done_q) begin
        cap_ev_q <= frame[31:30];
        cap_x_q  <= {frame[27:24], frame[23:16]};
        cap_y_q  <= {frame[11:8], frame[7:0]};
      end
      state_q <= state_d;
      if (upd_last) begin
        last_x_q <= cap_x_q;
        last_y_q <= cap_y_q;
      end
      if (cap_pend_q && rej && rej_q != 8'hFF)
        rej_q <= rej_q + 8'd1;
      if (push_ok)
        wr_q <= wr_q + 1'b1;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      head_t_q <= head_t_d;
      head_x_q <= head_x_d;
      head_y_q <= head_y_d;
      if (drop)
        ovf_q <= 1'b1;
      else if (clr_ovf)
        ovf_q <= 1'b0;
    end
  end

  assign evt_valid  = (cnt_q != '0);
  assign evt_type   = head_t_q;
  assign evt_x      = head_x_q;
  assign evt_y      = head_y_q;
  assign touching   = (state_q == PRESSED);
  assign overflow   = ovf_q;
  assign reject_cnt = rej_q;
  assign fifo_count = cnt_q;

endmodule
